// File: rtl/morse_receiver.sv
// Keyed Morse receiver: synchronizes and debounces a key, times marks and gaps in
// Morse units, decodes each character to a letter index and its tone-player pattern.
module morse_receiver #(
    parameter int UNIT_CYCLES     = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key,
    output logic        char_valid,
    output logic [4:0]  letter,
    output logic [16:0] code,
    output logic [2:0]  sym_cnt,
    output logic        err
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CYC_W = $clog2(UNIT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, MARK = 2'd1, SPACE = 2'd2} state_t;

    // Symbols are stored first-symbol-in-bit0, 1 = dash; bits above the count stay 0.
    function automatic logic [4:0] decode_letter(input logic [2:0] cnt, input logic [3:0] syms);
        logic [4:0] l;
        case ({cnt, syms})
            {3'd2, 4'b0010}: l = 5'd0;   {3'd4, 4'b0001}: l = 5'd1;
            {3'd4, 4'b0101}: l = 5'd2;   {3'd3, 4'b0001}: l = 5'd3;
            {3'd1, 4'b0000}: l = 5'd4;   {3'd4, 4'b0100}: l = 5'd5;
            {3'd3, 4'b0011}: l = 5'd6;   {3'd4, 4'b0000}: l = 5'd7;
            {3'd2, 4'b0000}: l = 5'd8;   {3'd4, 4'b1110}: l = 5'd9;
            {3'd3, 4'b0101}: l = 5'd10;  {3'd4, 4'b0010}: l = 5'd11;
            {3'd2, 4'b0011}: l = 5'd12;  {3'd2, 4'b0001}: l = 5'd13;
            {3'd3, 4'b0111}: l = 5'd14;  {3'd4, 4'b0110}: l = 5'd15;
            {3'd4, 4'b1011}: l = 5'd16;  {3'd3, 4'b0010}: l = 5'd17;
            {3'd3, 4'b0000}: l = 5'd18;  {3'd1, 4'b0001}: l = 5'd19;
            {3'd3, 4'b0100}: l = 5'd20;  {3'd4, 4'b1000}: l = 5'd21;
            {3'd3, 4'b0110}: l = 5'd22;  {3'd4, 4'b1001}: l = 5'd23;
            {3'd4, 4'b1101}: l = 5'd24;  {3'd4, 4'b0011}: l = 5'd25;
            default:         l = 5'd31;
        endcase
        return l;
    endfunction

    function automatic logic [16:0] build_code(input logic [2:0] cnt, input logic [3:0] syms);
        logic [16:0] c;
        int          pos;
        c   = 17'd0;
        pos = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(cnt)) begin
                if (syms[i]) begin
                    c[pos]     = 1'b1;
                    c[pos + 1] = 1'b1;
                    c[pos + 2] = 1'b1;
                    pos        = pos + 4;
                end else begin
                    c[pos] = 1'b1;
                    pos    = pos + 2;
                end
            end else begin
                pos = pos;
            end
        end
        return c;
    endfunction

    state_t             state_q, state_d;
    logic               key_meta_q, key_meta_d, key_sync_q, key_sync_d;
    logic               kd_q, kd_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d, cyc_inc_s;
    logic [2:0]         unit_cnt_q, unit_cnt_d, unit_inc_s;
    logic [3:0]         syms_q, syms_d;
    logic [2:0]         sym_count_q, sym_count_d;
    logic               char_valid_q, char_valid_d, err_q, err_d;
    logic [4:0]         letter_q, letter_d, dec_letter_s;
    logic [16:0]        code_q, code_d;
    logic [2:0]         sym_cnt_q, sym_cnt_d;
    logic               rise_s, fall_s;

    // Next-state logic: synchronizer, debouncer, unit timebase, symbol FSM and emit.
    always_comb begin
        state_d      = state_q;
        key_meta_d   = key;
        key_sync_d   = key_meta_q;
        kd_d         = kd_q;
        db_cnt_d     = db_cnt_q;
        syms_d       = syms_q;
        sym_count_d  = sym_count_q;
        char_valid_d = 1'b0;
        letter_d     = letter_q;
        code_d       = code_q;
        sym_cnt_d    = sym_cnt_q;
        err_d        = err_q;
        dec_letter_s = decode_letter(sym_count_q, syms_q);

        if (key_sync_q != kd_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                kd_d     = key_sync_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end
        rise_s = kd_d & ~kd_q;
        fall_s = ~kd_d & kd_q;

        // *_inc_s count the current cycle, so a mark of N cycles classifies as N/UNIT units.
        if (cyc_cnt_q == CYC_W'(UNIT_CYCLES - 1)) begin
            cyc_inc_s  = '0;
            unit_inc_s = (unit_cnt_q == 3'd7) ? 3'd7 : unit_cnt_q + 3'd1;
        end else begin
            cyc_inc_s  = cyc_cnt_q + CYC_W'(1);
            unit_inc_s = unit_cnt_q;
        end
        if (rise_s || fall_s) begin
            cyc_cnt_d  = '0;
            unit_cnt_d = 3'd0;
        end else begin
            cyc_cnt_d  = cyc_inc_s;
            unit_cnt_d = unit_inc_s;
        end

        case (state_q)
            IDLE: begin
                syms_d      = 4'd0;
                sym_count_d = 3'd0;
                if (rise_s) state_d = MARK;
                else        state_d = IDLE;
            end
            MARK: begin
                if (fall_s) begin
                    if (sym_count_q < 3'd4) syms_d[sym_count_q[1:0]] = (unit_inc_s >= 3'd2);
                    else                    syms_d = syms_q;
                    if (sym_count_q != 3'd5) sym_count_d = sym_count_q + 3'd1;
                    else                     sym_count_d = sym_count_q;
                    state_d = SPACE;
                end else begin
                    state_d = MARK;
                end
            end
            SPACE: begin
                // A press landing on the emit cycle starts the next character directly.
                if (unit_inc_s == 3'd3) begin
                    char_valid_d = 1'b1;
                    letter_d     = dec_letter_s;
                    err_d        = (dec_letter_s == 5'd31);
                    code_d       = (dec_letter_s == 5'd31) ? 17'd0 : build_code(sym_count_q, syms_q);
                    sym_cnt_d    = sym_count_q;
                    syms_d       = 4'd0;
                    sym_count_d  = 3'd0;
                    state_d      = rise_s ? MARK : IDLE;
                end else if (rise_s) begin
                    state_d = MARK;
                end else begin
                    state_d = SPACE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            key_meta_q   <= 1'b0;
            key_sync_q   <= 1'b0;
            kd_q         <= 1'b0;
            db_cnt_q     <= '0;
            cyc_cnt_q    <= '0;
            unit_cnt_q   <= 3'd0;
            syms_q       <= 4'd0;
            sym_count_q  <= 3'd0;
            char_valid_q <= 1'b0;
            letter_q     <= 5'd0;
            code_q       <= 17'd0;
            sym_cnt_q    <= 3'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_meta_q   <= key_meta_d;
            key_sync_q   <= key_sync_d;
            kd_q         <= kd_d;
            db_cnt_q     <= db_cnt_d;
            cyc_cnt_q    <= cyc_cnt_d;
            unit_cnt_q   <= unit_cnt_d;
            syms_q       <= syms_d;
            sym_count_q  <= sym_count_d;
            char_valid_q <= char_valid_d;
            letter_q     <= letter_d;
            code_q       <= code_d;
            sym_cnt_q    <= sym_cnt_d;
            err_q        <= err_d;
        end
    end

    assign char_valid = char_valid_q;
    assign letter     = letter_q;
    assign code       = code_q;
    assign sym_cnt    = sym_cnt_q;
    assign err        = err_q;
endmodule

// File: tb/tb_morse_receiver.sv
// Self-checking bench for morse_receiver: directed vector table, timing corner cases,
// and randomized keying checked against a string-based Morse reference model.
module tb_morse_receiver;
    localparam int U = 10;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        key;
    logic        char_valid;
    logic [4:0]  letter;
    logic [16:0] code;
    logic [2:0]  sym_cnt;
    logic        err;

    morse_receiver #(.UNIT_CYCLES(U), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .key(key), .char_valid(char_valid),
        .letter(letter), .code(code), .sym_cnt(sym_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  letter;
        logic [2:0]  cnt;
        logic [16:0] code;
        logic        err;
        int          at;
    } ev_t;

    typedef struct {
        int          n;
        logic [39:0] durs;
        logic [4:0]  letter;
        logic [2:0]  cnt;
        logic [16:0] code;
        logic        err;
    } vec_t;

    string morse_tbl [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                              ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                              "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    ev_t  evq[$];
    ev_t  expq[$];
    vec_t vecs[9];

    always @(posedge clk) cyc++;

    // Capture every char_valid pulse with its outputs and cycle stamp.
    always @(posedge clk) begin
        #1;
        if (char_valid === 1'b1) evq.push_back('{letter, sym_cnt, code, err, cyc});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: look the dot/dash string up in the Morse table, build "1"/"111" joined by "0".
    function automatic ev_t ref_char(input string s);
        ev_t   e;
        string bits;
        e.letter = 5'd31;
        e.cnt    = (s.len() > 4) ? 3'd5 : 3'(s.len());
        e.code   = 17'd0;
        e.err    = 1'b1;
        e.at     = 0;
        for (int l = 0; l < 26; l++) begin
            if (s == morse_tbl[l]) begin
                e.letter = 5'(l);
                e.err    = 1'b0;
                bits     = "";
                for (int i = 0; i < s.len(); i++) begin
                    if (i > 0) bits = {bits, "0"};
                    if (s[i] == ".") bits = {bits, "1"};
                    else             bits = {bits, "111"};
                end
                for (int j = 0; j < bits.len(); j++) e.code[j] = (bits[j] == "1");
            end
        end
        return e;
    endfunction

    task automatic key_pulse(input int p, input int g);
        key = 1'b1;
        repeat (p) @(negedge clk);
        key = 1'b0;
        repeat (g) @(negedge clk);
    endtask

    initial begin
        int    rel;
        int    p;
        int    g;
        int    n;
        string s;
        ev_t   e;

        vecs[0] = '{2, {8'd0, 8'd0, 8'd0, 8'd30, 8'd10},  5'd0,  3'd2, 17'h0001D, 1'b0};
        vecs[1] = '{1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd10},   5'd4,  3'd1, 17'h00001, 1'b0};
        vecs[2] = '{1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd19},   5'd4,  3'd1, 17'h00001, 1'b0};
        vecs[3] = '{1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd20},   5'd19, 3'd1, 17'h00007, 1'b0};
        vecs[4] = '{5, {8'd10, 8'd10, 8'd10, 8'd10, 8'd10}, 5'd31, 3'd5, 17'h00000, 1'b1};
        vecs[5] = '{4, {8'd0, 8'd30, 8'd30, 8'd30, 8'd30}, 5'd31, 3'd4, 17'h00000, 1'b1};
        vecs[6] = '{4, {8'd0, 8'd10, 8'd30, 8'd10, 8'd30}, 5'd2,  3'd4, 17'h005D7, 1'b0};
        vecs[7] = '{3, {8'd0, 8'd0, 8'd10, 8'd10, 8'd10},  5'd18, 3'd3, 17'h00015, 1'b0};
        vecs[8] = '{1, {8'd0, 8'd0, 8'd0, 8'd0, 8'd100},  5'd19, 3'd1, 17'h00007, 1'b0};

        rst = 1'b1;
        key = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_char_valid", 32'(char_valid), 32'd0);
        check("reset_letter",     32'(letter),     32'd0);
        check("reset_code",       32'(code),       32'd0);
        check("reset_sym_cnt",    32'(sym_cnt),    32'd0);
        check("reset_err",        32'(err),        32'd0);

        for (int v = 0; v < 9; v++) begin
            evq.delete();
            rel = 0;
            for (int i = 0; i < vecs[v].n; i++) begin
                key = 1'b1;
                repeat (int'(vecs[v].durs[i*8 +: 8])) @(negedge clk);
                key = 1'b0;
                rel = cyc;
                repeat ((i == vecs[v].n - 1) ? 60 : 10) @(negedge clk);
            end
            check($sformatf("vec%0d_events", v), 32'(evq.size()), 32'd1);
            if (evq.size() > 0) begin
                check($sformatf("vec%0d_letter", v), 32'(evq[0].letter), 32'(vecs[v].letter));
                check($sformatf("vec%0d_sym_cnt", v), 32'(evq[0].cnt), 32'(vecs[v].cnt));
                check($sformatf("vec%0d_code", v), 32'(evq[0].code), 32'(vecs[v].code));
                check($sformatf("vec%0d_err", v), 32'(evq[0].err), 32'(vecs[v].err));
                if (v == 0) check("vec0_emit_cycle", 32'(evq[0].at), 32'(rel + 2 + D + 3*U));
            end
            check($sformatf("vec%0d_held_letter", v), 32'(letter), 32'(vecs[v].letter));
            check($sformatf("vec%0d_pulse_low", v), 32'(char_valid), 32'd0);
        end

        // Gap of exactly 3 units: emit and new press coincide.
        evq.delete();
        key_pulse(10, 30);
        key_pulse(10, 60);
        check("gap30_events", 32'(evq.size()), 32'd2);
        if (evq.size() == 2) begin
            check("gap30_first",  32'(evq[0].letter), 32'd4);
            check("gap30_second", 32'(evq[1].letter), 32'd4);
        end

        // Gap one cycle short of 3 units stays in the same character.
        evq.delete();
        key_pulse(10, 29);
        key_pulse(10, 60);
        check("gap29_events", 32'(evq.size()), 32'd1);
        if (evq.size() > 0) begin
            check("gap29_letter", 32'(evq[0].letter), 32'd8);
            check("gap29_code",   32'(evq[0].code),   32'h5);
        end

        // Sub-debounce glitches around a clean dot.
        evq.delete();
        key_pulse(3, 6);
        key_pulse(10, 6);
        key_pulse(3, 60);
        check("glitch_events", 32'(evq.size()), 32'd1);
        if (evq.size() > 0) begin
            check("glitch_letter",  32'(evq[0].letter), 32'd4);
            check("glitch_sym_cnt", 32'(evq[0].cnt),    32'd1);
        end

        // Reset during the second symbol's mark.
        evq.delete();
        key_pulse(10, 10);
        key = 1'b1;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        key = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("rstmid_events",  32'(evq.size()), 32'd0);
        check("rstmid_outputs", {char_valid, letter, code, sym_cnt, err}, 32'd0);
        key_pulse(10, 60);
        check("rstmid_after_events", 32'(evq.size()), 32'd1);
        if (evq.size() > 0) check("rstmid_after_letter", 32'(evq[0].letter), 32'd4);

        // Randomized keying against the reference model.
        evq.delete();
        expq.delete();
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, 5);
            s = "";
            for (int i = 0; i < n; i++) begin
                p = $urandom_range(5, 45);
                if (p < 2*U) s = {s, "."};
                else         s = {s, "-"};
                g = (i == n - 1) ? 60 : $urandom_range(5, 35);
                if (g >= 3*U) begin
                    expq.push_back(ref_char(s));
                    s = "";
                end
                key_pulse(p, g);
            end
        end
        check("rand_event_count", 32'(evq.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
            e = expq[i];
            check($sformatf("rand_char%0d", i),
                  {6'd0, evq[i].letter, evq[i].cnt, evq[i].code, evq[i].err},
                  {6'd0, e.letter, e.cnt, e.code, e.err});
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
